// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: per-cycle mode codes,
// burst FSM states, and the burst-eligibility check.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SHL   = 3'd1;
  localparam logic [2:0] MODE_SHR   = 3'd2;
  localparam logic [2:0] MODE_ROL   = 3'd3;
  localparam logic [2:0] MODE_ROR   = 3'd4;
  localparam logic [2:0] MODE_ASR   = 3'd5;
  localparam logic [2:0] MODE_LOAD  = 3'd6;
  localparam logic [2:0] MODE_CLEAR = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Only the shift and rotate modes make sense to repeat autonomously.
  function automatic logic is_burst_mode(input logic [2:0] mode);
    return (mode >= MODE_SHL) && (mode <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_reg_core.sv
// Combinational next-value function of the universal shift register.
// Maps the current contents, mode, serial input and load data to q'.
module shift_reg_core
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_SHL:   q_next = {q[WIDTH-2:0], sin};
      MODE_SHR:   q_next = {sin, q[WIDTH-1:1]};
      MODE_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:   q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_LOAD:  q_next = pdata;
      MODE_CLEAR: q_next = RST_VAL;
      default:    q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with per-cycle modes and an autonomous burst engine
// that repeats one shift/rotate N times under i_en, reporting busy/done.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               LEN_W   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic             i_sin,
  input  logic [WIDTH-1:0] i_pdata,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic [WIDTH-1:0] o_q,
  output logic             o_sout_msb,
  output logic             o_sout_lsb,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [LEN_W-1:0] count;
  logic [2:0]       burst_mode;
  logic [2:0]       core_mode;
  logic             start_ok;

  // While bursting the latched mode drives the datapath; the live mode is ignored.
  assign core_mode = (state == ST_BURST) ? burst_mode : i_mode;
  assign start_ok  = (state == ST_IDLE) && i_start && is_burst_mode(i_mode)
                     && (i_len != {LEN_W{1'b0}});

  shift_reg_core #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_core (
    .q      (q_reg),
    .mode   (core_mode),
    .sin    (i_sin),
    .pdata  (i_pdata),
    .q_next (q_next)
  );

  // The start cycle only arms the burst; shifting begins on the next enabled cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= ST_IDLE;
      q_reg      <= RST_VAL;
      count      <= {LEN_W{1'b0}};
      burst_mode <= MODE_HOLD;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state      <= ST_BURST;
            burst_mode <= i_mode;
            count      <= i_len;
            o_busy     <= 1'b1;
          end else if (i_en) begin
            q_reg <= q_next;
          end
        end
        ST_BURST: begin
          if (i_en) begin
            q_reg <= q_next;
            count <= count - LEN_ONE;
            if (count == LEN_ONE) begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_q        = q_reg;
  assign o_sout_msb = q_reg[WIDTH-1];
  assign o_sout_lsb = q_reg[0];

endmodule
